// File: rtl/processador_pkg.sv
// Shared definitions for the parameterised processor core.
//   - opcode_t : 4-bit operation codes carried in instr[MSB -: OP_W]
//   - state_t  : control FSM states (single-cycle ops vs. iterative divide)
//   - flags_t  : status flags reported alongside each result
//   - FIELD_*  : field index of each register specifier; the field starts at
//                bit FIELD_x*AW, where AW = log2(NREGS)
package processador_pkg;

  localparam int OP_W     = 4;
  localparam int FIELD_RB = 0;
  localparam int FIELD_RA = 1;
  localparam int FIELD_RD = 2;
  localparam int FIELD_OP = 3;

  typedef enum logic [3:0] {
    OP_ADD = 4'h0,
    OP_SUB = 4'h1,
    OP_MUL = 4'h2,
    OP_DIV = 4'h3,
    OP_MOD = 4'h4,
    OP_AND = 4'h5,
    OP_OR  = 4'h6,
    OP_XOR = 4'h7,
    OP_NOT = 4'h8,
    OP_GT  = 4'h9,
    OP_GE  = 4'hA,
    OP_LT  = 4'hB,
    OP_LE  = 4'hC,
    OP_EQ  = 4'hD,
    OP_LDI = 4'hE,
    OP_NOP = 4'hF
  } opcode_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_DIV  = 1'b1
  } state_t;

  typedef struct packed {
    logic zero;
    logic carry;
    logic ovf;
    logic div0;
  } flags_t;

endpackage

// File: rtl/divisor_seq.sv
// Iterative restoring divider, one quotient bit per clock.
//   start     : load operands (single-cycle pulse)
//   dividend  : numerator, sampled on start
//   divisor   : denominator, sampled on start
//   done      : high during the cycle whose rising edge completes the last step;
//               quotient/remainder are valid in that same cycle
//   quotient  : result of the final step (combinational)
//   remainder : remainder of the final step (combinational)
//   div0      : latched divisor was zero
// Dividing by zero needs no special case: every trial subtraction succeeds,
// so the quotient fills with ones and the remainder collects the dividend.
module divisor_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div0
);

  localparam int CW = $clog2(WIDTH);

  logic             busy;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] q_r, rem_r, dvs_r;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH-1:0] trial, q_next, rem_next;
  logic             fits;

  // NOTE: every variable assigned in always_comb gets a value on every path
  // (here unconditionally first), otherwise synthesis infers a latch.
  always_comb begin
    rem_shift = {rem_r, q_r[WIDTH-1]};
    fits      = (rem_shift >= {1'b0, dvs_r});
    // When the trial fits, the true difference is below dvs_r, so the low
    // WIDTH bits hold it exactly.
    trial     = rem_shift[WIDTH-1:0] - dvs_r;
    rem_next  = fits ? trial : rem_shift[WIDTH-1:0];
    q_next    = {q_r[WIDTH-2:0], fits};
  end

  assign done      = busy && (count == CW'(WIDTH - 1));
  assign quotient  = q_next;
  assign remainder = rem_next;
  assign div0      = (dvs_r == '0);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy  <= 1'b0;
      count <= '0;
      q_r   <= '0;
      rem_r <= '0;
      dvs_r <= '0;
    end else if (start) begin
      busy  <= 1'b1;
      count <= '0;
      q_r   <= dividend;
      rem_r <= '0;
      dvs_r <= divisor;
    end else if (busy) begin
      q_r   <= q_next;
      rem_r <= rem_next;
      count <= count + 1'b1;
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/processador_param.sv
// Parameterised register-file processor core.
//   clk, rst_n        : clock, asynchronous active-low reset
//   instr_valid/ready : instruction handshake; ready is low only while dividing
//   instr             : {op[3:0], rd, ra, rb}, MSB first
//   imm               : LDI immediate, sampled at acceptance
//   res_valid         : one-cycle pulse after result/flags are updated
//   result, *_flag    : last result and its flags, held between pulses
//   dbg_addr/dbg_data : combinational register-file read port
// Single-cycle ops write back on the acceptance edge; DIV/MOD hand off to
// divisor_seq and write back WIDTH edges later.
module processador_param
  import processador_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NREGS = 8
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              instr_valid,
  output logic                              instr_ready,
  input  logic [OP_W+3*$clog2(NREGS)-1:0]   instr,
  input  logic [WIDTH-1:0]                  imm,
  output logic                              res_valid,
  output logic [WIDTH-1:0]                  result,
  output logic                              zero_flag,
  output logic                              carry_flag,
  output logic                              overflow_flag,
  output logic                              div0_flag,
  input  logic [$clog2(NREGS)-1:0]          dbg_addr,
  output logic [WIDTH-1:0]                  dbg_data
);

  localparam int AW = $clog2(NREGS);

  opcode_t          op;
  logic [AW-1:0]    rd, ra, rb;
  logic [WIDTH-1:0] regs [NREGS];
  logic [WIDTH-1:0] a, b;

  assign op = opcode_t'(instr[FIELD_OP*AW +: OP_W]);
  assign rd = instr[FIELD_RD*AW +: AW];
  assign ra = instr[FIELD_RA*AW +: AW];
  assign rb = instr[FIELD_RB*AW +: AW];
  assign a  = regs[ra];
  assign b  = regs[rb];

  assign dbg_data = regs[dbg_addr];

  state_t state_q, state_d;
  logic   accept, is_div, start_div;

  assign instr_ready = (state_q == ST_IDLE);
  assign accept      = instr_valid && instr_ready;
  assign is_div      = (op == OP_DIV) || (op == OP_MOD);
  assign start_div   = accept && is_div;

  // Single-cycle ALU
  logic [WIDTH:0]     sum, diff;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_carry, alu_ovf;

  always_comb begin
    sum       = {1'b0, a} + {1'b0, b};
    diff      = {1'b0, a} - {1'b0, b};
    prod      = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    alu_res   = '0;
    alu_carry = 1'b0;
    alu_ovf   = 1'b0;
    case (op)
      OP_ADD: begin
        alu_res   = sum[WIDTH-1:0];
        alu_carry = sum[WIDTH];
        alu_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res   = diff[WIDTH-1:0];
        alu_carry = diff[WIDTH];  // borrow, i.e. a < b
        alu_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_MUL: begin
        alu_res   = prod[WIDTH-1:0];
        alu_carry = |prod[2*WIDTH-1:WIDTH];
      end
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      OP_NOT:  alu_res = ~a;
      OP_GT:   alu_res = WIDTH'(a >  b);
      OP_GE:   alu_res = WIDTH'(a >= b);
      OP_LT:   alu_res = WIDTH'(a <  b);
      OP_LE:   alu_res = WIDTH'(a <= b);
      OP_EQ:   alu_res = WIDTH'(a == b);
      OP_LDI:  alu_res = imm;
      default: alu_res = '0;  // DIV/MOD come from the divider, NOP writes nothing
    endcase
  end

  // Iterative divider
  logic             div_done, div_zero;
  logic [WIDTH-1:0] div_q, div_r;

  divisor_seq #(.WIDTH(WIDTH)) u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start_div),
    .dividend  (a),
    .divisor   (b),
    .done      (div_done),
    .quotient  (div_q),
    .remainder (div_r),
    .div0      (div_zero)
  );

  // Control FSM
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start_div) state_d = ST_DIV;
      ST_DIV:  if (div_done)  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Writeback selection: divider completion and a single-cycle accept are
  // mutually exclusive because accept needs IDLE and done needs DIV.
  logic [AW-1:0]    rd_q;
  logic             mod_q;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  flags_t           wr_flags, flags_q;

  always_comb begin
    wr_en    = 1'b0;
    wr_addr  = rd;
    wr_data  = alu_res;
    wr_flags = '0;
    if (div_done) begin
      wr_en         = 1'b1;
      wr_addr       = rd_q;
      wr_data       = mod_q ? div_r : div_q;
      wr_flags.div0 = div_zero;
    end else if (accept && !is_div && (op != OP_NOP)) begin
      wr_en          = 1'b1;
      wr_flags.carry = alu_carry;
      wr_flags.ovf   = alu_ovf;
    end
    wr_flags.zero = (wr_data == '0);
  end

  // NOTE: the register file is reset like ordinary flops because the core
  // must power up with every register reading zero; this rules out mapping
  // it onto a RAM macro.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      result    <= '0;
      flags_q   <= '0;
      res_valid <= 1'b0;
      rd_q      <= '0;
      mod_q     <= 1'b0;
    end else begin
      res_valid <= 1'b0;
      if (start_div) begin
        rd_q  <= rd;
        mod_q <= (op == OP_MOD);
      end
      if (wr_en) begin
        regs[wr_addr] <= wr_data;
        result        <= wr_data;
        flags_q       <= wr_flags;
        res_valid     <= 1'b1;
      end
    end
  end

  assign zero_flag     = flags_q.zero;
  assign carry_flag    = flags_q.carry;
  assign overflow_flag = flags_q.ovf;
  assign div0_flag     = flags_q.div0;

endmodule

// File: tb/tb_processador_param.sv
// Self-checking bench for processador_param (WIDTH=8, NREGS=8): directed
// scenarios followed by random instructions, compared against an
// arithmetic reference model of the register file and flags.
module tb_processador_param;

  localparam int WIDTH = 8;
  localparam int NREGS = 8;
  localparam int AW    = 3;

  localparam int ADD = 0, SUB = 1, MUL = 2, DIV = 3, MOD = 4, AND_ = 5, OR_ = 6,
                 XOR_ = 7, NOT_ = 8, GT = 9, GE = 10, LT = 11, LE = 12, EQ = 13,
                 LDI = 14, NOP = 15;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              instr_valid = 1'b0;
  logic              instr_ready;
  logic [4+3*AW-1:0] instr = '0;
  logic [WIDTH-1:0]  imm = '0;
  logic              res_valid;
  logic [WIDTH-1:0]  result;
  logic              zero_flag, carry_flag, overflow_flag, div0_flag;
  logic [AW-1:0]     dbg_addr = '0;
  logic [WIDTH-1:0]  dbg_data;

  processador_param #(.WIDTH(WIDTH), .NREGS(NREGS)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr         (instr),
    .imm           (imm),
    .res_valid     (res_valid),
    .result        (result),
    .zero_flag     (zero_flag),
    .carry_flag    (carry_flag),
    .overflow_flag (overflow_flag),
    .div0_flag     (div0_flag),
    .dbg_addr      (dbg_addr),
    .dbg_data      (dbg_data)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  int mregs [NREGS];
  int m_result, m_z, m_c, m_v, m_d;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int to_s(input int x);
    return (x >= 128) ? x - 256 : x;
  endfunction

  task automatic model(input int op, input int a, input int b, input int immv,
                       output int r, output int c, output int v, output int d);
    int t;
    c = 0; v = 0; d = 0; r = 0;
    case (op)
      ADD: begin t = a + b; r = t % 256; c = int'(t > 255);
                 t = to_s(a) + to_s(b); v = int'(t > 127 || t < -128); end
      SUB: begin r = (a - b + 256) % 256; c = int'(a < b);
                 t = to_s(a) - to_s(b); v = int'(t > 127 || t < -128); end
      MUL: begin t = a * b; r = t % 256; c = int'(t > 255); end
      DIV: begin r = (b == 0) ? 255 : a / b; d = int'(b == 0); end
      MOD: begin r = (b == 0) ? a : a % b;   d = int'(b == 0); end
      AND_: r = a & b;
      OR_:  r = a | b;
      XOR_: r = a ^ b;
      NOT_: r = 255 - a;
      GT:   r = int'(a >  b);
      GE:   r = int'(a >= b);
      LT:   r = int'(a <  b);
      LE:   r = int'(a <= b);
      EQ:   r = int'(a == b);
      LDI:  r = immv;
      default: r = 0;
    endcase
  endtask

  task automatic model_reset();
    for (int i = 0; i < NREGS; i++) mregs[i] = 0;
    m_result = 0; m_z = 0; m_c = 0; m_v = 0; m_d = 0;
  endtask

  task automatic check_flags(input string tag);
    check({tag, "_result"}, result, m_result);
    check({tag, "_zero"}, zero_flag, m_z);
    check({tag, "_carry"}, carry_flag, m_c);
    check({tag, "_ovf"}, overflow_flag, m_v);
    check({tag, "_div0"}, div0_flag, m_d);
  endtask

  task automatic check_all_regs(input string tag);
    for (int i = 0; i < NREGS; i++) begin
      dbg_addr = AW'(i);
      #1;
      check(tag, dbg_data, mregs[i]);
    end
  endtask

  // Issue one instruction and check its outcome against the model.
  task automatic exec(input int op, input int rd, input int ra, input int rb, input int immv);
    int r, c, v, d;
    bit is_div;
    is_div = (op == DIV) || (op == MOD);
    @(negedge clk);
    check("ready_idle", instr_ready, 1);
    instr       = {4'(op), AW'(rd), AW'(ra), AW'(rb)};
    imm         = 8'(immv);
    instr_valid = 1'b1;
    model(op, mregs[ra], mregs[rb], immv, r, c, v, d);
    @(posedge clk); #1;
    if (is_div) begin
      // Keep offering an LDI that must be ignored while busy.
      instr = {4'(LDI), AW'(rd), AW'(ra), AW'(rb)};
      imm   = ~imm;
      check("div_ready_low", instr_ready, 0);
      check("div_no_valid", res_valid, 0);
      for (int i = 1; i < WIDTH; i++) begin
        @(posedge clk); #1;
        check("div_ready_low", instr_ready, 0);
        check("div_no_valid", res_valid, 0);
      end
      @(posedge clk); #1;
    end
    instr_valid = 1'b0;
    if (op == NOP) begin
      check("nop_no_valid", res_valid, 0);
      check("nop_result", result, m_result);
    end else begin
      mregs[rd] = r;
      m_result = r; m_z = int'(r == 0); m_c = c; m_v = v; m_d = d;
      check("res_valid", res_valid, 1);
      check_flags("op");
      check("ready_after", instr_ready, 1);
      dbg_addr = AW'(rd);
      #1;
      check("dbg_rd", dbg_data, mregs[rd]);
    end
  endtask

  // One idle cycle: the pulse must drop and the outputs must hold.
  task automatic hold_check();
    @(posedge clk); #1;
    check("hold_no_valid", res_valid, 0);
    check_flags("hold");
  endtask

  initial begin
    int op, rd, ra, rb, immv;
    model_reset();

    // Reset state
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", instr_ready, 1);
    check("rst_valid", res_valid, 0);
    check_flags("rst");
    check_all_regs("rst_reg");
    @(negedge clk); rst_n = 1'b1;

    // Directed arithmetic sequence
    exec(LDI, 0, 0, 0, 200);
    exec(LDI, 1, 0, 0, 100);
    exec(ADD, 2, 0, 1, 0);
    check("add_value", result, 8'h2C);
    check("add_carry", carry_flag, 1);
    exec(SUB, 3, 1, 0, 0);
    check("sub_value", result, 8'h9C);
    check("sub_ovf", overflow_flag, 1);
    exec(MUL, 4, 0, 1, 0);
    check("mul_value", result, 8'h20);
    hold_check();
    exec(LDI, 5, 0, 0, 7);
    exec(DIV, 6, 0, 5, 0);
    check("div_value", result, 8'h1C);
    exec(MOD, 7, 0, 5, 0);
    check("mod_value", result, 8'h04);
    hold_check();
    exec(LDI, 5, 0, 0, 0);
    exec(DIV, 6, 0, 5, 0);
    check("div0_value", result, 8'hFF);
    check("div0_flag", div0_flag, 1);
    exec(MOD, 0, 0, 5, 0);
    check("mod0_value", result, 8'd200);
    exec(NOP, 1, 2, 3, 0);
    exec(ADD, 1, 1, 1, 0);   // rd == ra == rb
    exec(EQ, 2, 1, 1, 0);
    check_all_regs("dir_reg");

    // Reset three cycles into a divide
    @(negedge clk);
    instr       = {4'(DIV), AW'(6), AW'(0), AW'(1)};
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("abort_ready", instr_ready, 1);
    check("abort_valid", res_valid, 0);
    check_all_regs("abort_reg");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < WIDTH + 2; i++) begin
      @(posedge clk); #1;
      check("abort_no_valid", res_valid, 0);
    end
    check_flags("abort");
    check_all_regs("abort_reg2");

    // Random instructions
    for (int n = 0; n < 160; n++) begin
      op   = (n < 8) ? LDI : int'($urandom_range(0, 15));
      rd   = (n < 8) ? n : int'($urandom_range(0, NREGS - 1));
      ra   = int'($urandom_range(0, NREGS - 1));
      rb   = int'($urandom_range(0, NREGS - 1));
      immv = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 255));
      exec(op, rd, ra, rb, immv);
      if ($urandom_range(0, 7) == 0 && op != NOP) hold_check();
    end
    check_all_regs("final_reg");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
